// File: rtl/imem_loader_pkg.sv
// Shared types and sizing constants for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int COUNT_WIDTH    = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in (valid/ready) and instruction memory write bus out, as seen by the loader.
interface imem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into words; word_valid marks the accept that completes one.
module byte_packer
    import loader_pkg::*;
(
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        accept,
    input  logic [7:0]                  data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_valid
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]                  idx_reg;
    logic [8*(BYTES_PER_WORD-1)-1:0]   partial;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
        end else if (clear) begin
            idx_reg <= '0;
        end else if (accept) begin
            idx_reg <= idx_reg + 1'b1;
        end
    end

    // The top byte is never stored: it is combined straight from the input on the final accept.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge CLK or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (clear) begin
                    lane_reg <= '0;
                end else if (accept && (idx_reg == IDX_W'(gi))) begin
                    lane_reg <= data;
                end
            end
            assign partial[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign word_valid = accept && !clear && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));
    assign word       = {data, partial};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header-counted byte stream -> 32-bit instruction memory writes, holding the CPU in reset until done.
module imem_loader
    import loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hBFC00000),
    parameter int                    MAX_WORDS  = 1024
)(
    input  logic          CLK,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

    state_t                     state_reg;
    logic [8*HDR_BYTES-1:0]     count_reg;
    logic [COUNT_WIDTH-1:0]     word_idx_reg;
    logic [COUNT_WIDTH-1:0]     hdr_count;
    logic                       accept;
    logic                       last_word_written;
    logic                       pk_clear;
    logic                       pk_accept;
    logic                       pk_valid;
    logic [8*BYTES_PER_WORD-1:0] pk_word;

    assign accept            = bus.rx_valid && bus.rx_ready;
    assign hdr_count         = {bus.rx_data, count_reg[7:0]};
    assign last_word_written = (word_idx_reg == count_reg);
    assign pk_clear          = (state_reg == HDR_HI) && accept;
    // Bytes arriving during the final write pulse are outside the image and never packed.
    assign pk_accept         = (state_reg == DATA) && accept && !last_word_written;

    byte_packer u_packer (
        .CLK        (CLK),
        .rst        (rst),
        .clear      (pk_clear),
        .accept     (pk_accept),
        .data       (bus.rx_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            word_idx_reg   <= '0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= '0;
            cpu_rst        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= HDR_LO;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count_reg[7:0] <= bus.rx_data;
                        state_reg      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        count_reg <= hdr_count;
                        if (hdr_count == '0) begin
                            state_reg    <= DONE;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            cpu_rst      <= 1'b0;
                        end else if (32'(hdr_count) > MAX_WORDS_U) begin
                            state_reg    <= ERR;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            state_reg    <= DATA;
                            word_idx_reg <= '0;
                        end
                    end
                end
                DATA: begin
                    // Completion is taken one cycle after the last write so rx_ready spans the pulse.
                    if (last_word_written) begin
                        state_reg    <= DONE;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        cpu_rst      <= 1'b0;
                    end else if (pk_valid) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_wdata <= DATA_WIDTH'(pk_word);
                        bus.imem_addr  <= BASE_ADDR + ADDR_WIDTH'({word_idx_reg, 2'b00});
                        word_idx_reg   <= word_idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_reg    <= HDR_LO;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        cpu_rst      <= 1'b1;
                    end
                end
                ERR: begin
                    if (start) begin
                        state_reg    <= HDR_LO;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        error        <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header handling, packing, stalls, errors, reset and reload.
module tb_imem_loader;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_rst, busy, done, error;

    imem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    imem_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'hBFC00000),
        .MAX_WORDS  (1024)
    ) dut (
        .CLK     (CLK),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  img_q[$];
    logic        cpu_rst_held;
    logic [31:0] exp_a[2] = '{32'hBFC00000, 32'hBFC00004};
    logic [31:0] exp_d[2] = '{32'h00100513, 32'h00200593};

    always @(negedge CLK) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
            $display("write addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: rx_ready=%b required 1 (byte %h)", bus.rx_ready, b);
        end
        tick();
        bus.rx_valid = 1'b0;
        $display("byte %h sent", b);
    endtask

    // Sends img_q with gap idle cycles between bytes; start is held at hold_start while sending.
    task automatic send_image(input int gap, input logic hold_start);
        cpu_rst_held = 1'b1;
        start = hold_start;
        for (int i = 0; i < img_q.size(); i++) begin
            send_byte(img_q[i]);
            if (i != img_q.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (cpu_rst !== 1'b1) cpu_rst_held = 1'b0;
                    tick();
                end
                if (cpu_rst !== 1'b1) cpu_rst_held = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_two_word_image();
        img_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    endtask

    task automatic test_reset();
        checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b exp 0", bus.rx_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b exp 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL reset_imem_addr: got %h exp bfc00000", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_imem_wdata: got %h exp 0", bus.imem_wdata); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b exp 1", cpu_rst); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/error got %b exp 000", {busy, done, error}); end
    endtask

    task automatic test_start_with_valid();
        bus.rx_data  = 8'h05;
        bus.rx_valid = 1'b1;
        pulse_start();
        checks++; if (bus.rx_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_hdr_lo: rx_ready/busy got %b%b exp 11", bus.rx_ready, busy); end
        send_byte(8'h00);
        send_byte(8'h00);
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL start_valid_ignored: done/cpu_rst got %b%b exp 10", done, cpu_rst); end
    endtask

    task automatic test_load_basic();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++; if ({cpu_rst, busy, done} !== 3'b110) begin errors++; $display("FAIL basic_start: cpu_rst/busy/done got %b exp 110", {cpu_rst, busy, done}); end
        load_two_word_image();
        send_image(0, 1'b0);
        checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 32'hBFC00004 || bus.imem_wdata !== 32'h00200593)
            begin errors++; $display("FAIL basic_last_pulse: we=%b addr=%h data=%h exp 1 bfc00004 00200593", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b exp 0", done); end
        tick();
        checks++; if ({done, cpu_rst, busy, bus.imem_we, bus.rx_ready} !== 5'b10000)
            begin errors++; $display("FAIL basic_done: done/cpu_rst/busy/we/rx_ready got %b exp 10000", {done, cpu_rst, busy, bus.imem_we, bus.rx_ready}); end
        checks++;
        if (wa_q.size() != 2) begin errors++; $display("FAIL basic_write_count: got %0d exp 2", wa_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin errors++; $display("FAIL basic_write%0d: got %h/%h exp %h/%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]); end
        end
    endtask

    task automatic test_stall();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        load_two_word_image();
        send_image(3, 1'b1);
        repeat (6) tick();
        checks++; if (cpu_rst_held !== 1'b1) begin errors++; $display("FAIL stall_cpu_rst_held: got %b exp 1", cpu_rst_held); end
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL stall_done: done/cpu_rst got %b%b exp 10", done, cpu_rst); end
        checks++;
        if (wa_q.size() != 2) begin errors++; $display("FAIL stall_write_count: got %0d exp 2", wa_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin errors++; $display("FAIL stall_write%0d: got %h/%h exp %h/%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]); end
        end
    endtask

    task automatic test_oversize();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        checks++; if ({error, cpu_rst, busy, bus.rx_ready, done} !== 5'b11000)
            begin errors++; $display("FAIL oversize_err: error/cpu_rst/busy/rx_ready/done got %b exp 11000", {error, cpu_rst, busy, bus.rx_ready, done}); end
        repeat (3) tick();
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL oversize_writes: got %0d exp 0", wa_q.size()); end
        pulse_start();
        checks++; if ({error, bus.rx_ready, busy} !== 3'b011) begin errors++; $display("FAIL oversize_restart: error/rx_ready/busy got %b exp 011", {error, bus.rx_ready, busy}); end
    endtask

    task automatic test_zero_count();
        wa_q.delete(); wd_q.delete();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++; if ({done, cpu_rst, busy} !== 3'b100) begin errors++; $display("FAIL zero_done: done/cpu_rst/busy got %b exp 100", {done, cpu_rst, busy}); end
        repeat (2) tick();
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d exp 0", wa_q.size()); end
    endtask

    task automatic test_rst_mid();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        img_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
        send_image(0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b exp 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.imem_we, cpu_rst, busy, done, bus.rx_ready} !== 5'b01000)
            begin errors++; $display("FAIL rst_mid_async: we/cpu_rst/busy/done/rx_ready got %b exp 01000", {bus.imem_we, cpu_rst, busy, done, bus.rx_ready}); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL rst_mid_partial: writes got %0d exp 1", wa_q.size()); end
        wa_q.delete(); wd_q.delete();
        pulse_start();
        load_two_word_image();
        send_image(0, 1'b0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_mid_reload_done: got %b exp 1", done); end
        checks++;
        if (wa_q.size() != 2) begin errors++; $display("FAIL rst_mid_write_count: got %0d exp 2", wa_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            checks++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin errors++; $display("FAIL rst_mid_write%0d: got %h/%h exp %h/%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]); end
        end
    endtask

    task automatic test_reload();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reload_start: cpu_rst/done got %b%b exp 10", cpu_rst, done); end
        img_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_image(0, 1'b0);
        checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 32'hBFC00000 || bus.imem_wdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL reload_write: we=%b addr=%h data=%h exp 1 bfc00000 deadbeef", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
        tick();
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL reload_done: done/cpu_rst got %b%b exp 10", done, cpu_rst); end
        repeat (3) tick();
        checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL reload_write_count: got %0d exp 1", wa_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
        test_reset();
        test_start_with_valid();
        test_load_basic();
        test_stall();
        test_oversize();
        test_zero_count();
        test_rst_mid();
        test_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader and write-side counterpart of the CPU's instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Writes each word into instruction memory starting at BASE_ADDR.
- Holds the CPU in reset (cpu_rst) until the whole image is written, then releases it.

Parameters:
DATA_WIDTH, 32, instruction word width (fixed 4 bytes per word)
ADDR_WIDTH, 32, instruction memory address width
BASE_ADDR, 32'hBFC00000, byte address of first written word
MAX_WORDS, 1024, instruction memory depth in words; larger images are rejected

Ports:
CLK  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin load; sampled only in IDLE, DONE, ERR
rx_data  input  8  stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  ADDR_WIDTH  byte address of write
imem_wdata  output  DATA_WIDTH  word to write
cpu_rst  output  1  CPU reset hold, high until a load completes
busy  output  1  load in progress
done  output  1  image fully written; CPU released
error  output  1  sticky header error

Behaviour:
- Reset values, applied asynchronously:
  - state=IDLE; rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_rst=1, busy=0, done=0, error=0.
  - Byte index, word index and partial word all cleared.
- Byte transfer: a byte is accepted on a rising edge only when rx_valid=1 and rx_ready=1. rx_data is ignored otherwise.
- Stream format: count_lo, count_hi (16-bit word count N, little-endian), then 4*N data bytes. Within each word, byte k lands in bits [8k+7:8k].
- States:
  - IDLE: rx_ready=0. On start=1, go to HDR_LO; busy=1 from the next cycle.
  - HDR_LO: rx_ready=1. On accept, count[7:0]=byte; go to HDR_HI.
  - HDR_HI: rx_ready=1. On accept, count[15:8]=byte. Then:
    - N==0: go to DONE.
    - N>MAX_WORDS: go to ERR.
    - otherwise: go to DATA, with word index=0 and byte index=0.
  - DATA: rx_ready=1. Each accepted byte increments the byte index (mod 4). When the 4th byte is accepted on edge E:
    - On edge E: imem_wdata=the assembled word, imem_addr=BASE_ADDR+4*word_index (mod 2^ADDR_WIDTH), imem_we=1 for exactly one cycle.
    - The word index increments.
    - rx_ready stays 1 during the write pulse, so throughput is 1 byte/cycle.
    - When this was word N, go to DONE: rx_ready=0 from the edge after E.
  - DONE: entered one cycle after the last imem_we pulse. done=1, busy=0, cpu_rst=0, rx_ready=0. On start=1: cpu_rst=1, done=0, go to HDR_LO (reload).
  - ERR: error=1, cpu_rst=1, busy=0, rx_ready=0; no memory writes. On start=1: error=0, go to HDR_LO.
- start during HDR_LO, HDR_HI or DATA is ignored.
- Simultaneous events:
  - start and rx_valid in IDLE: the byte is not accepted (rx_ready=0).
  - Final-byte accept and start on the same edge: start is ignored.
- When N==0, done rises the cycle after the count_hi accept and no imem_we pulse occurs.
- rst asserted mid-load: all reset values apply immediately.
  - imem_we drops asynchronously and the partial word is discarded.
  - cpu_rst=1.
  - No completion is reported for the interrupted load.
- Stalls: rx_valid=0 for any number of cycles holds all state. imem_we never repeats.

Decomposition:
- Package loader_pkg:
  - state enum (IDLE, HDR_LO, HDR_HI, DATA, DONE, ERR)
  - BYTES_PER_WORD=4
  - HDR_BYTES=2
  - COUNT_WIDTH=16
- One sub-module, byte_packer: takes byte + accept, outputs word + word_valid pulse, with a clear input driven on entry to DATA.
- Top level holds the FSM, counters, address generation and cpu_rst/done/error.

Test Plan:
- Load N=2, bytes 02 00 13 05 10 00 93 05 20 00, rx_valid continuous -> imem_we pulses:
  - (0xBFC00000, 0x00100513), then (0xBFC00004, 0x00200593);
  - done=1 and cpu_rst=0 one cycle after the second pulse.
- Same image with rx_valid low for 3 cycles between every byte -> identical writes and values; no extra imem_we pulses; cpu_rst held high throughout the load.
- Header N=0x0401 (1025 > MAX_WORDS) -> error=1 one cycle after count_hi, cpu_rst=1, no imem_we; then start -> error=0, state HDR_LO, rx_ready=1.
- Header 00 00 -> done=1 the cycle after count_hi accept; no writes; cpu_rst=0.
- rst pulse after 5 data bytes of an N=2 load -> imem_we=0, cpu_rst=1, busy=0 asynchronously; a fresh start plus full image writes correctly from 0xBFC00000.
- In DONE, assert start and send N=1 image 01 00 EF BE AD DE -> cpu_rst rises, one write (0xBFC00000, 0xDEADBEEF), then done=1 and cpu_rst=0.
